block_ram_burst_reader: RTL and testbench
=========================================

Name: block_ram_burst_reader

Overview:
- Read-side initiator for the synchronous single-port block RAMs in the design (one-cycle registered read, `ram[address]` appears on the data bus the cycle after the address is presented).
- On a start pulse, sweeps a contiguous address range with wrap-around.
- Returns the words as a valid/ready stream with backpressure, flags the last word, and pulses done.
- Sits between any preloaded coefficient/pattern RAM and a downstream consumer.

Parameters:
- blockLength, 32: word width, in bits.
- memDepth, 64: number of RAM words. Any value ≥2 is legal, not only powers of two.
- addressBitWidth, 6: RAM address width. Must satisfy 2^addressBitWidth ≥ memDepth.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: burst request. Sampled only when busy=0.
- startAddress, input, addressBitWidth: first address of the burst. Sampled with start.
- burstLength, input, addressBitWidth+1: number of words. 0 is legal; values above memDepth are clamped to memDepth.
- busy, output, 1: burst in progress.
- done, output, 1: one-cycle completion pulse.
- memAddress, output, addressBitWidth: RAM read address.
- memRead, output, 1: RAM read strobe, high in each issue cycle.
- memData, input, blockLength: RAM read data. Valid the cycle after memRead.
- dataOut, output, blockLength: stream data.
- valid, output, 1: stream data valid.
- ready, input, 1: consumer accepts data.
- last, output, 1: marks the final word of the burst.

Behaviour:
- Reset (asynchronous, any time, including mid-burst) forces all outputs low/zero: busy, done, memAddress, memRead, dataOut, valid, last.
  - The FIFO and in-flight tracking are cleared.
  - RAM data returning after reset deassertion is discarded.
- State machine states: IDLE, RUN, FINISH.
  - IDLE → RUN: on start=1 with clamped burstLength > 0. The start edge latches the address counter = startAddress and remaining = clamped burstLength. busy=1 from the next cycle.
  - IDLE → FINISH: on start=1 with burstLength = 0. No memRead and no valid are produced.
  - RUN → FINISH: at the edge where the last word handshakes (valid & ready & last).
  - FINISH → IDLE: unconditional after one cycle. In FINISH, done=1 and busy=0.
  - start while busy (RUN or FINISH) is ignored.
- Read issue rules:
  - A read is issued in a RUN cycle when remaining > 0 and (FIFO entries + in-flight reads − pop this cycle) < 2.
  - memRead=1 in an issue cycle. memAddress is driven from the address counter.
  - On each issue, remaining decrements and the address counter increments, wrapping from memDepth−1 to 0.
  - memAddress holds its value when no read is issued.
- Return path:
  - The in-flight flag is set on issue. The word on memData is pushed into the 2-entry FIFO on the following edge.
  - The FIFO head drives dataOut/valid.
  - last is stored per entry. It is set on the word whose issue made remaining 1→0.
- Latency and throughput:
  - start sampled at edge E0 → first memRead in cycle 1 → memData valid in cycle 2 → valid=1 in cycle 3.
  - With ready held at 1: one word per cycle. An N-word burst has valid high in cycles 3..N+2, done in cycle N+3.
- Stream rules:
  - While valid=1 and ready=0, dataOut and last are held stable.
  - valid never drops without a handshake.
  - ready is ignored while valid=0.
- Boundary conditions:
  - A 2-entry FIFO never overflows under any ready pattern. Issue stalls while it is full.
  - Simultaneous push and pop on a full FIFO is legal.
  - A burst crossing memDepth−1 continues at 0.
  - burstLength = memDepth reads every word exactly once.
  - A burst with startAddress ≥ memDepth has undefined data. The address counter still wraps at memDepth.

Decomposition:
- Shared include: FSM state encodings (IDLE, RUN, FINISH) and the FIFO depth constant (2).
- One sub-module: stream_skid_fifo (2-entry FIFO, blockLength+1 wide).
  - Ports: push, pushData, pop, popData, count, empty, full.
  - Reset: clock plus asynchronous active-high reset.
- The top level holds the FSM, address/remaining counters, issue-credit logic and in-flight flag.

Test Plan:
- Reset then idle: after reset, all outputs are 0. No memRead occurs for 20 cycles with start=0.
- Full-rate burst: RAM preloaded with `ram[i]=i`; startAddress=5, burstLength=4, ready=1 → dataOut 5,6,7,8 on cycles 3–6. last is high only with word 8; done is pulsed in cycle 7.
- Wrap and clamp:
  - memDepth=64, startAddress=62, burstLength=3 → 62,63,0.
  - burstLength=100 → exactly 64 words, last on word 61 (startAddress=62).
- Backpressure: random ready at 30% duty, burstLength=16 → all 16 words arrive in order, with no duplicates or drops. dataOut is stable during every valid&!ready cycle. memRead never fires with FIFO+in-flight = 2.
- Edge requests:
  - burstLength=0 → done pulses once, with no memRead and no valid.
  - start asserted during RUN → ignored, and the burst count is unchanged.
- Reset mid-burst: assert reset in cycle 4 of a 10-word burst → outputs clear immediately, asynchronously. No valid appears after release until a new start; a new burst then runs correctly.

Source files
------------

// File: rtl/block_ram_burst_reader_pkg.sv
// Shared constants and FSM encoding for the block RAM burst reader.
package block_ram_burst_reader_pkg;

   localparam int unsigned FIFO_DEPTH   = 2;
   localparam int unsigned FIFO_COUNT_W = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/block_ram_burst_reader_stream_skid_fifo.sv
// Two-entry FIFO; the head register drives the stream directly, and vacated
// slots are zeroed so an empty FIFO presents zero data and a clear last flag.
module stream_skid_fifo
   import block_ram_burst_reader_pkg::*;
#(
   parameter int unsigned width = 33
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  logic [width-1:0]        pushData,
   input  logic                    pop,
   output logic [width-1:0]        popData,
   output logic [FIFO_COUNT_W-1:0] count,
   output logic                    empty,
   output logic                    full
);

   logic [width-1:0] tail;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FIFO_COUNT_W'(FIFO_DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         popData <= '0;
         tail    <= '0;
         count   <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (empty) popData <= pushData;
               else       tail    <= pushData;
               count <= count + FIFO_COUNT_W'(1);
            end
            2'b01: begin
               popData <= tail;
               tail    <= '0;
               count   <= count - FIFO_COUNT_W'(1);
            end
            2'b11: begin
               if (full) begin
                  popData <= tail;
                  tail    <= pushData;
               end else begin
                  popData <= pushData;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/block_ram_burst_reader.sv
// Burst read initiator for a one-cycle-latency block RAM: sweeps a wrapping
// address range and returns the words as a valid/ready stream.
module block_ram_burst_reader
   import block_ram_burst_reader_pkg::*;
#(
   parameter int unsigned blockLength     = 32,
   parameter int unsigned memDepth        = 64,
   parameter int unsigned addressBitWidth = 6
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [addressBitWidth-1:0] startAddress,
   input  logic [addressBitWidth:0]   burstLength,
   output logic                       busy,
   output logic                       done,
   output logic [addressBitWidth-1:0] memAddress,
   output logic                       memRead,
   input  logic [blockLength-1:0]     memData,
   output logic [blockLength-1:0]     dataOut,
   output logic                       valid,
   input  logic                       ready,
   output logic                       last
);

   localparam int unsigned LEN_W = addressBitWidth + 1;
   localparam int unsigned OCC_W = FIFO_COUNT_W + 1;
   localparam logic [LEN_W-1:0]           MAX_LEN   = LEN_W'(memDepth);
   localparam logic [addressBitWidth-1:0] LAST_ADDR = addressBitWidth'(memDepth - 1);

   state_t                  state;
   logic [LEN_W-1:0]        remaining;
   logic [LEN_W-1:0]        clamped;
   logic                    in_flight;
   logic                    in_flight_last;
   logic [FIFO_COUNT_W-1:0] fifo_count;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic [blockLength:0]    head;
   logic                    pop;

   assign clamped = (burstLength > MAX_LEN) ? MAX_LEN : burstLength;
   assign valid   = ~fifo_empty;
   assign pop     = valid & ready;
   assign dataOut = head[blockLength-1:0];
   assign last    = head[blockLength];

   // Issue credit: queued words plus the read in flight, less this cycle's pop, must leave a slot
   assign memRead = (state == RUN) && (remaining != '0) && (~fifo_full || pop) &&
                    ((OCC_W'(fifo_count) + OCC_W'(in_flight)) < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop)));

   stream_skid_fifo #(
      .width (blockLength + 1)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (in_flight),
      .pushData ({in_flight_last, memData}),
      .pop      (pop),
      .popData  (head),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         memAddress     <= '0;
         remaining      <= '0;
         in_flight      <= 1'b0;
         in_flight_last <= 1'b0;
      end else begin
         in_flight      <= memRead;
         in_flight_last <= memRead && (remaining == LEN_W'(1));
         case (state)
            IDLE: begin
               if (start) begin
                  memAddress <= startAddress;
                  remaining  <= clamped;
                  if (clamped != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (memRead) begin
                  remaining  <= remaining - LEN_W'(1);
                  memAddress <= (memAddress >= LAST_ADDR) ? '0 : memAddress + addressBitWidth'(1);
               end
               if (pop && last) begin
                  state <= FINISH;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FINISH: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_block_ram_burst_reader.sv
// Self-checking bench for block_ram_burst_reader against a wrap-around burst model.
module tb_block_ram_burst_reader;

   localparam int unsigned BL = 32;
   localparam int unsigned MD = 64;
   localparam int unsigned AW = 6;
   localparam int unsigned LW = AW + 1;

   logic          clock;
   logic          reset;
   logic          start;
   logic [AW-1:0] startAddress;
   logic [LW-1:0] burstLength;
   logic          busy;
   logic          done;
   logic [AW-1:0] memAddress;
   logic          memRead;
   logic [BL-1:0] memData;
   logic [BL-1:0] dataOut;
   logic          valid;
   logic          ready;
   logic          last;

   logic [BL-1:0] ram [MD];

   int checks;
   int errors;

   logic [BL-1:0] got_data[$];
   bit            got_last[$];
   int            got_cycle[$];
   int            cyc, done_cnt, done_cycle, issued, accepted, busy_cnt, valid_cnt;
   int            unstable, over_issue;
   bit            prev_stall;
   logic [BL-1:0] prev_data;
   logic          prev_last;

   block_ram_burst_reader #(
      .blockLength     (BL),
      .memDepth        (MD),
      .addressBitWidth (AW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .startAddress (startAddress),
      .burstLength  (burstLength),
      .busy         (busy),
      .done         (done),
      .memAddress   (memAddress),
      .memRead      (memRead),
      .memData      (memData),
      .dataOut      (dataOut),
      .valid        (valid),
      .ready        (ready),
      .last         (last)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Synchronous RAM: registered read, junk on the bus when no read was issued
   always @(posedge clock) memData <= memRead ? ram[memAddress] : $urandom;

   function automatic logic [BL-1:0] model_word(input int sa, input int i);
      return ram[(sa + i) % MD];
   endfunction

   function automatic int model_len(input int len);
      return (len > MD) ? MD : len;
   endfunction

   task automatic clear_obs();
      got_data.delete(); got_last.delete(); got_cycle.delete();
      cyc = 0; done_cnt = 0; done_cycle = -1; issued = 0; accepted = 0;
      busy_cnt = 0; valid_cnt = 0; unstable = 0; over_issue = 0; prev_stall = 0;
      prev_data = '0; prev_last = 1'b0;
   endtask

   task automatic begin_burst(input int sa, input int len);
      startAddress = AW'(sa);
      burstLength  = LW'(len);
      start        = 1'b1;
   endtask

   // Run n cycles with ready at the given duty (percent), recording what the DUT did
   task automatic collect(input int n, input int duty);
      for (int c = 0; c < n; c++) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         ready = (int'($urandom_range(99)) < duty);
         @(negedge clock);
         cyc++;
         if (prev_stall && (!valid || dataOut !== prev_data || last !== prev_last)) unstable++;
         if (memRead) begin
            if (issued - accepted - int'(valid && ready) >= 2) over_issue++;
            issued++;
         end
         if (busy) busy_cnt++;
         if (valid) valid_cnt++;
         if (done) begin
            done_cnt++;
            done_cycle = cyc;
         end
         if (valid && ready) begin
            got_data.push_back(dataOut);
            got_last.push_back(last);
            got_cycle.push_back(cyc);
            accepted++;
         end
         prev_stall = valid && !ready;
         prev_data  = dataOut;
         prev_last  = last;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; ready = 1'b0; startAddress = '0; burstLength = '0;
      #3;
      checks++;
      if ({busy, done, memRead, valid, last, memAddress, dataOut} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b rd=%b valid=%b last=%b addr=%0d data=%h, want all 0",
                  busy, done, memRead, valid, last, memAddress, dataOut);
      end
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      clear_obs();
      collect(20, 50);
      checks++;
      if (issued !== 0 || valid_cnt !== 0 || done_cnt !== 0 || busy_cnt !== 0) begin
         errors++;
         $display("FAIL idle_quiet: reads=%0d valids=%0d dones=%0d busy=%0d, want 0", issued, valid_cnt, done_cnt, busy_cnt);
      end
   endtask

   task automatic test_full_rate();
      for (int i = 0; i < MD; i++) ram[i] = BL'(i);
      begin_burst(5, 4);
      clear_obs();
      collect(10, 100);
      checks++;
      if (got_data.size() !== 4) begin
         errors++;
         $display("FAIL full_rate_count: got %0d words, want 4", got_data.size());
      end
      for (int i = 0; i < 4 && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== model_word(5, i) || got_last[i] !== (i == 3) || got_cycle[i] !== 3 + i) begin
            errors++;
            $display("FAIL full_rate_word%0d: data=%0d last=%b cycle=%0d, want data=%0d last=%b cycle=%0d",
                     i, got_data[i], got_last[i], got_cycle[i], model_word(5, i), (i == 3), 3 + i);
         end
      end
      checks++;
      if (done_cnt !== 1 || done_cycle !== 7 || issued !== 4 || busy_cnt !== 6) begin
         errors++;
         $display("FAIL full_rate_timing: dones=%0d done_cycle=%0d reads=%0d busy_cycles=%0d, want 1 7 4 6",
                  done_cnt, done_cycle, issued, busy_cnt);
      end
   endtask

   task automatic test_wrap_clamp();
      int sa_list [2];
      int len_list[2];
      sa_list  = '{62, 62};
      len_list = '{3, 100};
      for (int t = 0; t < 2; t++) begin
         int n;
         n = model_len(len_list[t]);
         begin_burst(sa_list[t], len_list[t]);
         clear_obs();
         collect(n + 16, 100);
         checks++;
         if (got_data.size() !== n || done_cnt !== 1 || issued !== n) begin
            errors++;
            $display("FAIL wrap_len%0d_count: words=%0d dones=%0d reads=%0d, want %0d 1 %0d",
                     len_list[t], got_data.size(), done_cnt, issued, n, n);
         end
         for (int i = 0; i < n && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== model_word(sa_list[t], i) || got_last[i] !== (i == n - 1)) begin
               errors++;
               $display("FAIL wrap_len%0d_word%0d: data=%0d last=%b, want data=%0d last=%b",
                        len_list[t], i, got_data[i], got_last[i], model_word(sa_list[t], i), (i == n - 1));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < MD; i++) ram[i] = $urandom;
      for (int r = 0; r < 3; r++) begin
         int sa;
         sa = int'($urandom_range(MD - 1));
         begin_burst(sa, 16);
         clear_obs();
         collect(250, 30);
         checks++;
         if (got_data.size() !== 16 || done_cnt !== 1 || unstable !== 0 || over_issue !== 0) begin
            errors++;
            $display("FAIL backpressure_r%0d: words=%0d dones=%0d unstable=%0d over_issue=%0d, want 16 1 0 0",
                     r, got_data.size(), done_cnt, unstable, over_issue);
         end
         for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== model_word(sa, i) || got_last[i] !== (i == 15)) begin
               errors++;
               $display("FAIL backpressure_r%0d_word%0d: data=%h last=%b, want data=%h last=%b",
                        r, i, got_data[i], got_last[i], model_word(sa, i), (i == 15));
            end
         end
      end
   endtask

   task automatic test_zero_length();
      begin_burst(int'($urandom_range(MD - 1)), 0);
      clear_obs();
      collect(10, 100);
      checks++;
      if (done_cnt !== 1 || done_cycle !== 1 || issued !== 0 || valid_cnt !== 0 || busy_cnt !== 0) begin
         errors++;
         $display("FAIL zero_length: dones=%0d done_cycle=%0d reads=%0d valids=%0d busy=%0d, want 1 1 0 0 0",
                  done_cnt, done_cycle, issued, valid_cnt, busy_cnt);
      end
   endtask

   task automatic test_start_during_run();
      int sa;
      sa = int'($urandom_range(MD - 1));
      begin_burst(sa, 6);
      clear_obs();
      collect(2, 100);
      begin_burst(int'($urandom_range(MD - 1)), 20);
      collect(20, 100);
      checks++;
      if (got_data.size() !== 6 || done_cnt !== 1 || issued !== 6) begin
         errors++;
         $display("FAIL start_in_run_count: words=%0d dones=%0d reads=%0d, want 6 1 6", got_data.size(), done_cnt, issued);
      end
      for (int i = 0; i < 6 && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== model_word(sa, i) || got_last[i] !== (i == 5)) begin
            errors++;
            $display("FAIL start_in_run_word%0d: data=%h last=%b, want data=%h last=%b",
                     i, got_data[i], got_last[i], model_word(sa, i), (i == 5));
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int sa;
      begin_burst(int'($urandom_range(MD - 1)), 10);
      clear_obs();
      collect(3, 100);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, memRead, valid, last, memAddress, dataOut} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: busy=%b done=%b rd=%b valid=%b last=%b addr=%0d data=%h, want all 0",
                  busy, done, memRead, valid, last, memAddress, dataOut);
      end
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      clear_obs();
      collect(15, 100);
      checks++;
      if (valid_cnt !== 0 || issued !== 0 || done_cnt !== 0 || busy_cnt !== 0) begin
         errors++;
         $display("FAIL mid_reset_quiet: valids=%0d reads=%0d dones=%0d busy=%0d, want 0", valid_cnt, issued, done_cnt, busy_cnt);
      end
      sa = int'($urandom_range(MD - 1));
      begin_burst(sa, 10);
      clear_obs();
      collect(40, 60);
      checks++;
      if (got_data.size() !== 10 || done_cnt !== 1 || unstable !== 0) begin
         errors++;
         $display("FAIL mid_reset_rerun_count: words=%0d dones=%0d unstable=%0d, want 10 1 0", got_data.size(), done_cnt, unstable);
      end
      for (int i = 0; i < 10 && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== model_word(sa, i) || got_last[i] !== (i == 9)) begin
            errors++;
            $display("FAIL mid_reset_rerun_word%0d: data=%h last=%b, want data=%h last=%b",
                     i, got_data[i], got_last[i], model_word(sa, i), (i == 9));
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < MD; i++) ram[i] = BL'(i);
      test_reset();
      test_full_rate();
      test_wrap_clamp();
      test_backpressure();
      test_zero_length();
      test_start_during_run();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
